// File: rtl/ctc_word_seq.sv
// A&R serial-bus word sequencer: 56-bit-time frame, serial instruction broadcast,
// word-select window and carry capture. Optional sticky carry via CARRY_STICKY_EN.
module ctc_word_seq #(
  parameter int WORD_LEN   = 56,
  parameter int SYNC_FIRST = 45
) (
  input  logic       cph2,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [9:0] instr,
  output logic       instr_ready,
  input  logic [3:0] ptr,
  input  logic       carry_in,
  input  logic       carry_clr,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic [5:0] bit_time,
  output logic       carry_flag,
  output logic       carry_vld
);

  localparam logic [5:0] LAST = 6'(WORD_LEN - 1);
  localparam logic [5:0] SF   = 6'(SYNC_FIRST);
  localparam logic [5:0] SL   = 6'(SYNC_FIRST + 9);
  localparam logic [5:0] RDY  = 6'(SYNC_FIRST - 1);

  // Handshake: instr_ready is high only at bit time 44; an instruction is
  // transferred on the cph2 edge ending a cycle with instr_valid && instr_ready.
  // Without a transfer the broadcast word is a NOP.

  logic [5:0] cnt, cnt_nxt;
  logic [9:0] bcast_r, bcast_nxt;
  logic [9:0] exec_r, exec_nxt;
  logic [3:0] exec_ptr, ptr_nxt;
  logic [3:0] d, idx;
  logic       sync_nxt, is_nxt, ws_nxt, flag_nxt;
  logic       unused_bits;

  assign bit_time = cnt;

  always_comb begin
    cnt_nxt   = (cnt == LAST) ? 6'd0 : cnt + 6'd1;
    bcast_nxt = bcast_r;
    exec_nxt  = exec_r;
    ptr_nxt   = exec_ptr;
    if (cnt == RDY) bcast_nxt = instr_valid ? instr : 10'h000;
    if (cnt == LAST) begin
      exec_nxt = bcast_r;
      ptr_nxt  = ptr;
    end

    // Outputs are decoded from the next count so they leave flops cleanly.
    sync_nxt = (cnt_nxt >= SF) && (cnt_nxt <= SL);
    idx      = 4'(cnt_nxt - SF);
    is_nxt   = sync_nxt ? bcast_nxt[idx] : 1'b0;

    d = cnt_nxt[5:2];
    case (exec_nxt[4:2])
      3'd0:    ws_nxt = (d == ptr_nxt);
      3'd1:    ws_nxt = (d >= 4'd3) && (d <= 4'd12);
      3'd2:    ws_nxt = (d <= 4'd2);
      3'd3:    ws_nxt = 1'b1;
      3'd4:    ws_nxt = (d <= ptr_nxt);
      3'd5:    ws_nxt = (d >= 4'd3);
      3'd6:    ws_nxt = (d == 4'd2);
      default: ws_nxt = (d == 4'd13);
    endcase
    if (exec_nxt[1:0] != 2'b10) ws_nxt = 1'b0;

    // The pending carry is carry_in as sampled on the edge leaving bit time 55;
    // it lands in carry_flag so that flag and carry_vld are both seen at bit time 0.
    flag_nxt = carry_flag;
    if (cnt == LAST) begin
`ifdef CARRY_STICKY_EN
      flag_nxt = carry_clr ? carry_in : (carry_flag | carry_in);
`else
      flag_nxt = carry_in;
`endif
    end
  end

`ifdef CARRY_STICKY_EN
  assign unused_bits = ^exec_r[9:5];
`else
  assign unused_bits = ^{exec_r[9:5], carry_clr};
`endif

  always_ff @(posedge cph2 or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 6'd0;
      bcast_r     <= 10'h000;
      exec_r      <= 10'h000;
      exec_ptr    <= 4'd0;
      sync        <= 1'b0;
      is          <= 1'b0;
      ws          <= 1'b0;
      instr_ready <= 1'b0;
      carry_flag  <= 1'b0;
      carry_vld   <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      bcast_r     <= bcast_nxt;
      exec_r      <= exec_nxt;
      exec_ptr    <= ptr_nxt;
      sync        <= sync_nxt;
      is          <= is_nxt;
      ws          <= ws_nxt;
      instr_ready <= (cnt_nxt == RDY);
      carry_flag  <= flag_nxt;
      carry_vld   <= (cnt == LAST);
    end
  end

endmodule

// File: tb/tb_ctc_word_seq.sv
// Directed bench for ctc_word_seq: whole-word output vectors against hand-built
// expectations, back-to-back instructions, carry capture and mid-word reset.
module tb_ctc_word_seq;

  logic       cph2 = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;
  logic [3:0] ptr;
  logic       carry_in, carry_clr;
  logic       sync, is, ws;
  logic [5:0] bit_time;
  logic       carry_flag, carry_vld;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  localparam int NW = 15;
  logic       t_valid[NW];
  logic [9:0] t_instr[NW];
  logic [3:0] t_ptr[NW];
  logic       t_ci[NW], t_clr[NW], t_on[NW], t_flag[NW], t_vld[NW];
  int         t_lo[NW], t_hi[NW];

  ctc_word_seq dut (
    .cph2(cph2), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ptr(ptr), .carry_in(carry_in), .carry_clr(carry_clr),
    .sync(sync), .is(is), .ws(ws), .bit_time(bit_time),
    .carry_flag(carry_flag), .carry_vld(carry_vld)
  );

  // clock / reset
  always #5 cph2 = ~cph2;

  task automatic check(input string tag, input logic [55:0] got, input logic [55:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_row(input int w, input logic v, input logic [9:0] ins, input logic [3:0] p,
                         input logic ci, input logic clr, input logic on, input int lo,
                         input int hi, input logic f, input logic vl);
    t_valid[w] = v; t_instr[w] = ins; t_ptr[w] = p; t_ci[w] = ci; t_clr[w] = clr;
    t_on[w] = on; t_lo[w] = lo; t_hi[w] = hi; t_flag[w] = f; t_vld[w] = vl;
  endtask

  // driver + capture of one full word starting at bit time 0
  task automatic run_word(input int w);
    logic [55:0] s_v, i_v, w_v, r_v, v_v, f_v, bt_v;
    logic [55:0] s_e, i_e, w_e, r_e, v_e;
    logic [9:0]  b;
    exp_q.push_back(t_valid[w] ? t_instr[w] : 10'h000);
    for (int k = 0; k < 56; k++) begin
      s_v[k] = sync; i_v[k] = is; w_v[k] = ws; r_v[k] = instr_ready;
      v_v[k] = carry_vld; f_v[k] = carry_flag; bt_v[k] = (bit_time == 6'(k));
      instr_valid = (k == 44) ? t_valid[w] : 1'($urandom_range(0, 1));
      instr       = (k == 44) ? t_instr[w] : 10'($urandom_range(0, 1023));
      ptr         = (k == 55) ? t_ptr[w]   : 4'($urandom_range(0, 15));
      carry_in    = (k == 55) ? t_ci[w]    : 1'($urandom_range(0, 1));
      carry_clr   = (k == 55) ? t_clr[w]   : 1'($urandom_range(0, 1));
      @(negedge cph2);
    end
    s_e = '0; i_e = '0; w_e = '0; r_e = '0; v_e = '0;
    b = exp_q.pop_front();
    for (int j = 0; j < 10; j++) begin
      s_e[45 + j] = 1'b1;
      i_e[45 + j] = b[j];
    end
    if (t_on[w]) for (int j = t_lo[w]; j <= t_hi[w]; j++) w_e[j] = 1'b1;
    r_e[44] = 1'b1;
    v_e[0]  = t_vld[w];
    check($sformatf("w%0d bit_time", w), bt_v, {56{1'b1}});
    check($sformatf("w%0d sync", w), s_v, s_e);
    check($sformatf("w%0d is", w), i_v, i_e);
    check($sformatf("w%0d ws", w), w_v, w_e);
    check($sformatf("w%0d ready", w), r_v, r_e);
    check($sformatf("w%0d carry_vld", w), v_v, v_e);
    check($sformatf("w%0d carry_flag", w), f_v, {56{t_flag[w]}});
  endtask

  initial begin
    logic sticky;
`ifdef CARRY_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    //       w  vld instr              ptr ci clr on lo hi flag vld0
    set_row( 0, 0, 10'h000,            0, 0, 0, 0, 0, 0, 0, 0);
    set_row( 1, 0, 10'h000,            0, 0, 0, 0, 0, 0, 0, 1);
    set_row( 2, 0, 10'h000,            0, 0, 0, 0, 0, 0, 0, 1);
    set_row( 3, 1, 10'b01110_011_10,   0, 0, 0, 0, 0, 0, 0, 1);
    set_row( 4, 1, 10'b00001_000_10,   5, 1, 0, 1, 0, 55, 0, 1);
    set_row( 5, 1, 10'b00010_100_10,   5, 0, 0, 1, 20, 23, 1, 1);
    set_row( 6, 1, 10'b00011_110_10,   0, 0, 1, 1, 0, 23, sticky, 1);
    set_row( 7, 1, 10'b00100_101_10,   0, 0, 0, 1, 8, 11, 0, 1);
    set_row( 8, 1, 10'b11111_011_00,   0, 0, 0, 1, 12, 55, 0, 1);
    set_row( 9, 1, 10'b00001_000_10,  15, 0, 0, 0, 0, 0, 0, 1);
    set_row(10, 1, 10'b00010_100_10,  14, 0, 0, 0, 0, 0, 0, 1);
    set_row(11, 1, 10'b00101_001_10,   3, 0, 0, 1, 0, 55, 0, 1);
    set_row(12, 1, 10'b00110_010_10,   0, 1, 0, 1, 12, 51, 0, 1);
    set_row(13, 1, 10'b00111_111_10,   0, 0, 1, 1, 0, 11, 1, 1);
    set_row(14, 1, 10'b01110_011_10,   0, 0, 0, 1, 52, 55, 0, 1);

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ptr = '0; carry_in = 1'b0; carry_clr = 1'b0;
    repeat (3) @(negedge cph2);
    check("rst bit_time", 56'(bit_time), 56'd0);
    check("rst outs", 56'({sync, is, ws, instr_ready, carry_vld, carry_flag}), 56'd0);
    rst_n = 1'b1;

    for (int w = 0; w < NW; w++) run_word(w);

    // word 15 executes field W; reset lands in the middle of its window
    for (int k = 0; k < 30; k++) begin
      instr_valid = 1'b0;
      carry_in = 1'($urandom_range(0, 1));
      @(negedge cph2);
    end
    check("pre-rst bit_time", 56'(bit_time), 56'd30);
    check("pre-rst ws", 56'(ws), 56'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst ws/sync/is", 56'({ws, sync, is}), 56'd0);
    check("mid-rst bit_time", 56'(bit_time), 56'd0);
    repeat (2) @(negedge cph2);
    rst_n = 1'b1;
    run_word(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
